// File: rtl/counter_pkg.sv
// Shared constants and types for the free-running binary counter.
// The default width is also the width of count_t.
package counter_pkg;

    localparam int COUNTER_WIDTH = 8;

    typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter.sv
// Free-running binary up-counter with synchronous reset and a terminal-count flag.
// The count wraps from MAX_VALUE to zero, so the period is MAX_VALUE+1 cycles.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH,
    parameter int MAX_VALUE = (2**WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q = MAX_VALUE[WIDTH-1:0];

    // Wrapping on the MAX_VALUE compare means values above MAX_VALUE cannot be reached after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (q == MAX_Q) begin
            q <= '0;
        end else begin
            q <= q + WIDTH'(1);
        end
    end

    assign tc = (q == MAX_Q);

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: a default 8-bit instance and a 4-bit instance that wraps after 9,
// each checked against hand-computed values and a modulo reference model.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset8;
    logic       reset4;
    logic [7:0] q8;
    logic       tc8;
    logic [3:0] q4;
    logic       tc4;

    int checks   = 0;
    int failures = 0;
    int m8       = -1;
    int m4       = -1;

    always #5 clk = ~clk;

    counter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .q     (q8),
        .tc    (tc8)
    );

    counter #(.WIDTH(4), .MAX_VALUE(9)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .q     (q4),
        .tc    (tc4)
    );

    // Reference model: next = (prev + 1) mod (MAX_VALUE + 1), cleared on reset.
    always @(posedge clk) begin
        if (reset8) m8 <= 0;
        else if (m8 >= 0) m8 <= (m8 + 1) % 256;
        if (reset4) m4 <= 0;
        else if (m4 >= 0) m4 <= (m4 + 1) % 10;
    end

    task automatic test_reset();
        reset8 = 1'b1;
        reset4 = 1'b1;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            checks++;
            if (q8 !== 8'd0) begin
                failures++;
                $display("FAIL reset_q8 t=%0t got=%0d exp=0", $time, q8);
            end
            checks++;
            if (tc8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_tc8 t=%0t got=%b exp=0", $time, tc8);
            end
            checks++;
            if (q4 !== 4'd0) begin
                failures++;
                $display("FAIL reset_q4 t=%0t got=%0d exp=0", $time, q4);
            end
            checks++;
            if (tc4 !== 1'b0) begin
                failures++;
                $display("FAIL reset_tc4 t=%0t got=%b exp=0", $time, tc4);
            end
        end
        reset8 = 1'b0;
        reset4 = 1'b0;
    endtask

    task automatic test_count_up();
        logic [7:0] exp_q;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            exp_q = 8'(i);
            checks++;
            if (q8 !== exp_q) begin
                failures++;
                $display("FAIL count_up_q t=%0t got=%0d exp=%0d", $time, q8, exp_q);
            end
            checks++;
            if (tc8 !== 1'b0) begin
                failures++;
                $display("FAIL count_up_tc t=%0t got=%b exp=0", $time, tc8);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_q;
        reset8 = 1'b1;
        @(negedge clk);
        checks++;
        if (q8 !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset_q t=%0t got=%0d exp=0", $time, q8);
        end
        checks++;
        if (tc8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_tc t=%0t got=%b exp=0", $time, tc8);
        end
        reset8 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_q = 8'(i);
            checks++;
            if (q8 !== exp_q) begin
                failures++;
                $display("FAIL mid_reset_resume t=%0t got=%0d exp=%0d", $time, q8, exp_q);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q;
        logic       exp_tc;
        int         pulses;
        for (int i = 21; i <= 257; i++) begin
            @(negedge clk);
            exp_q  = 8'(i % 256);
            exp_tc = (i == 255);
            checks++;
            if (q8 !== exp_q) begin
                failures++;
                $display("FAIL wrap_q t=%0t got=%0d exp=%0d", $time, q8, exp_q);
            end
            checks++;
            if (tc8 !== exp_tc) begin
                failures++;
                $display("FAIL wrap_tc t=%0t q=%0d got=%b exp=%b", $time, q8, tc8, exp_tc);
            end
        end
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (tc8 === 1'b1) pulses++;
            checks++;
            if (q8 !== 8'(m8)) begin
                failures++;
                $display("FAIL wrap_model t=%0t got=%0d exp=%0d", $time, q8, m8);
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL wrap_tc_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_custom_max();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tc4 === 1'b1) pulses++;
            checks++;
            if (q4 !== 4'(m4)) begin
                failures++;
                $display("FAIL custom_q t=%0t got=%0d exp=%0d", $time, q4, m4);
            end
            checks++;
            if (!(q4 <= 4'd9)) begin
                failures++;
                $display("FAIL custom_range t=%0t got=%0d exp<=9", $time, q4);
            end
            checks++;
            if (tc4 !== (m4 == 9)) begin
                failures++;
                $display("FAIL custom_tc t=%0t got=%b exp=%b", $time, tc4, (m4 == 9));
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL custom_tc_pulses got=%0d exp=3", pulses);
        end
    endtask

    task automatic test_reset_at_tc();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (tc8 === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tc8_timeout got=no_tc exp=tc_within_300");
        end else begin
            reset8 = 1'b1;
            @(negedge clk);
            checks++;
            if (q8 !== 8'd0) begin
                failures++;
                $display("FAIL reset_at_tc_q8 t=%0t got=%0d exp=0", $time, q8);
            end
            checks++;
            if (tc8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_at_tc_tc8 t=%0t got=%b exp=0", $time, tc8);
            end
            reset8 = 1'b0;
            @(negedge clk);
            checks++;
            if (q8 !== 8'd1) begin
                failures++;
                $display("FAIL reset_at_tc_resume8 t=%0t got=%0d exp=1", $time, q8);
            end
        end

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tc4 === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL tc4_timeout got=no_tc exp=tc_within_20");
        end else begin
            checks++;
            if (q4 !== 4'd9) begin
                failures++;
                $display("FAIL tc4_value t=%0t got=%0d exp=9", $time, q4);
            end
            reset4 = 1'b1;
            @(negedge clk);
            checks++;
            if (q4 !== 4'd0) begin
                failures++;
                $display("FAIL reset_at_tc_q4 t=%0t got=%0d exp=0", $time, q4);
            end
            checks++;
            if (tc4 !== 1'b0) begin
                failures++;
                $display("FAIL reset_at_tc_tc4 t=%0t got=%b exp=0", $time, tc4);
            end
            reset4 = 1'b0;
            @(negedge clk);
            checks++;
            if (q4 !== 4'd1) begin
                failures++;
                $display("FAIL reset_at_tc_resume4 t=%0t got=%0d exp=1", $time, q4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_mid_reset();
        test_wrap();
        test_custom_max();
        test_reset_at_tc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
